// File: rtl/spu_writeback_stage.sv
// SPU writeback stage: per-pipe latency queues feeding the two register-file write ports.
// Optional SPU_WB_COLLISION_CNT_EN adds a saturating 16-bit collision_count output.

module spu_wb_queue #(
  parameter int DEPTH  = 7,
  parameter int ADDR_W = 7,
  parameter int DATA_W = 128
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  input  logic [2:0]        in_lat,
  input  logic [3:0]        in_stamp,
  input  logic              in_tie,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic [3:0]        out_stamp,
  output logic              out_tie,
  output logic              err
);
  logic [DEPTH-1:0]             vld_pipe;
  logic [DEPTH-1:0][ADDR_W-1:0] addr;
  logic [DEPTH-1:0][DATA_W-1:0] data;
  logic [DEPTH-1:0][3:0]        stamp;
  logic [DEPTH-1:0]             tie;
  logic                         occ, accept;
  logic [2:0]                   tgt;

  // Target slot L-1 is taken after the shift exactly when the current slot L is valid.
  always_comb begin
    occ = 1'b0;
    for (int k = 1; k < DEPTH; k++)
      if (int'(in_lat) == k) occ = vld_pipe[k];
    accept = in_valid && (in_lat != 3'd0) && (int'(in_lat) <= DEPTH) && !occ;
    tgt    = in_lat - 3'd1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vld_pipe <= '0;
      addr     <= '0;
      data     <= '0;
      stamp    <= '0;
      tie      <= '0;
      err      <= 1'b0;
    end else begin
      for (int k = 0; k < DEPTH-1; k++) begin
        vld_pipe[k] <= vld_pipe[k+1];
        addr[k]     <= addr[k+1];
        data[k]     <= data[k+1];
        stamp[k]    <= stamp[k+1];
        tie[k]      <= tie[k+1];
      end
      vld_pipe[DEPTH-1] <= 1'b0;
      if (accept) begin
        vld_pipe[tgt] <= 1'b1;
        addr[tgt]     <= in_addr;
        data[tgt]     <= in_data;
        stamp[tgt]    <= in_stamp;
        tie[tgt]      <= in_tie;
      end
      err <= in_valid && !accept;
    end
  end

  assign out_valid = vld_pipe[0];
  assign out_addr  = addr[0];
  assign out_data  = data[0];
  assign out_stamp = stamp[0];
  assign out_tie   = tie[0];
endmodule

module spu_writeback_stage #(
  parameter int DEPTH  = 7,
  parameter int ADDR_W = 7,
  parameter int DATA_W = 128
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ep_valid,
  input  logic [ADDR_W-1:0] ep_rt_address,
  input  logic [DATA_W-1:0] ep_result,
  input  logic [2:0]        ep_latency,
  input  logic              op_valid,
  input  logic [ADDR_W-1:0] op_rt_address,
  input  logic [DATA_W-1:0] op_result,
  input  logic [2:0]        op_latency,
  input  logic              op_younger,
  output logic [ADDR_W-1:0] rt_ep_address,
  output logic [DATA_W-1:0] rt_value_ep,
  output logic              wrt_en_ep,
  output logic [ADDR_W-1:0] rt_op_address,
  output logic [DATA_W-1:0] rt_value_op,
  output logic              wrt_en_op,
  output logic [1:0]        insert_err
`ifdef SPU_WB_COLLISION_CNT_EN
  ,output logic [15:0]      collision_count
`endif
);
  // Index 0 = even pipe, 1 = odd pipe.
  logic [1:0]             in_vld, in_tie, q_vld, q_tie;
  logic [1:0][ADDR_W-1:0] in_addr, q_addr;
  logic [1:0][DATA_W-1:0] in_data, q_data;
  logic [1:0][2:0]        in_lat;
  logic [1:0][3:0]        q_stamp;
  logic [3:0]             stamp_cnt, diff_eo;
  logic                   both, col, even_younger;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) stamp_cnt <= 4'd0;
    else        stamp_cnt <= stamp_cnt + 4'd1;
  end

  assign both    = ep_valid & op_valid;
  assign in_vld  = {op_valid, ep_valid};
  assign in_addr = {op_rt_address, ep_rt_address};
  assign in_data = {op_result, ep_result};
  assign in_lat  = {op_latency, ep_latency};
  assign in_tie  = {both & op_younger, both & ~op_younger};

  genvar p;
  for (p = 0; p < 2; p++) begin : g_pipe
    spu_wb_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_q (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (in_vld[p]),
      .in_addr   (in_addr[p]),
      .in_data   (in_data[p]),
      .in_lat    (in_lat[p]),
      .in_stamp  (stamp_cnt),
      .in_tie    (in_tie[p]),
      .out_valid (q_vld[p]),
      .out_addr  (q_addr[p]),
      .out_data  (q_data[p]),
      .out_stamp (q_stamp[p]),
      .out_tie   (q_tie[p]),
      .err       (insert_err[p])
    );
  end

  // Stamps wrap mod 16; entries retiring together were issued < DEPTH cycles apart.
  assign diff_eo      = q_stamp[0] - q_stamp[1];
  assign even_younger = (diff_eo == 4'd0) ? q_tie[0]
                                          : (int'(diff_eo) <= DEPTH);
  assign col          = q_vld[0] & q_vld[1] & (q_addr[0] == q_addr[1]);

  assign wrt_en_ep     = q_vld[0] & ~(col & ~even_younger);
  assign wrt_en_op     = q_vld[1] & ~(col & even_younger);
  assign rt_ep_address = q_addr[0];
  assign rt_value_ep   = q_data[0];
  assign rt_op_address = q_addr[1];
  assign rt_value_op   = q_data[1];

`ifdef SPU_WB_COLLISION_CNT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                                 collision_count <= 16'd0;
    else if (col && collision_count != 16'hFFFF) collision_count <= collision_count + 16'd1;
  end
`endif
endmodule

// File: tb/tb_spu_writeback_stage.sv
// Scoreboard bench for spu_writeback_stage: model keeps pending writes keyed by retire cycle.
module tb_spu_writeback_stage;
  localparam int DEPTH = 7, AW = 7, DW = 128;

  logic clock = 1'b0, reset = 1'b0;
  logic ep_valid = 0, op_valid = 0, op_younger = 0;
  logic [AW-1:0] ep_rt_address = 0, op_rt_address = 0;
  logic [DW-1:0] ep_result = 0, op_result = 0;
  logic [2:0] ep_latency = 0, op_latency = 0;
  logic [AW-1:0] rt_ep_address, rt_op_address;
  logic [DW-1:0] rt_value_ep, rt_value_op;
  logic wrt_en_ep, wrt_en_op;
  logic [1:0] insert_err;
`ifdef SPU_WB_COLLISION_CNT_EN
  logic [15:0] collision_count;
`endif

  spu_writeback_stage dut (
    .clock(clock), .reset(reset),
    .ep_valid(ep_valid), .ep_rt_address(ep_rt_address), .ep_result(ep_result), .ep_latency(ep_latency),
    .op_valid(op_valid), .op_rt_address(op_rt_address), .op_result(op_result), .op_latency(op_latency),
    .op_younger(op_younger),
    .rt_ep_address(rt_ep_address), .rt_value_ep(rt_value_ep), .wrt_en_ep(wrt_en_ep),
    .rt_op_address(rt_op_address), .rt_value_op(rt_value_op), .wrt_en_op(wrt_en_op),
    .insert_err(insert_err)
`ifdef SPU_WB_COLLISION_CNT_EN
    , .collision_count(collision_count)
`endif
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            issue;
    logic          oy;
  } ent_t;

  ent_t     pend_e[int];
  ent_t     pend_o[int];
  bit [1:0] exp_err[int];
  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // Drive one cycle of stimulus; model decides acceptance from retire-cycle occupancy.
  task automatic issue(input logic ev, input logic [AW-1:0] ea, input logic [DW-1:0] ed, input int el,
                       input logic ov, input logic [AW-1:0] oa, input logic [DW-1:0] od, input int ol,
                       input logic oy);
    int t;
    t = cyc;
    ep_valid = ev; ep_rt_address = ea; ep_result = ed; ep_latency = 3'(el);
    op_valid = ov; op_rt_address = oa; op_result = od; op_latency = 3'(ol);
    op_younger = oy;
    if (reset) begin
      if (ev) begin
        if (el >= 1 && el <= DEPTH && !pend_e.exists(t + el)) pend_e[t + el] = '{ea, ed, t, oy};
        else exp_err[t + 1] = exp_err[t + 1] | 2'b01;
      end
      if (ov) begin
        if (ol >= 1 && ol <= DEPTH && !pend_o.exists(t + ol)) pend_o[t + ol] = '{oa, od, t, oy};
        else exp_err[t + 1] = exp_err[t + 1] | 2'b10;
      end
    end
    @(posedge clock); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) issue(0, 0, 0, 1, 0, 0, 0, 1, 0);
  endtask

  task automatic assert_reset(input int n);
    reset = 1'b0;
    pend_e.delete(); pend_o.delete(); exp_err.delete();
    ep_valid = 0; op_valid = 0;
    for (int i = 0; i < n; i++) begin @(posedge clock); #1; end
    reset = 1'b1;
  endtask

  // Monitor: every cycle compare DUT ports with the writes the model expects to retire now.
  always @(negedge clock) begin
    ent_t e, o;
    bit ve, vo, col, ey;
    bit [1:0] ee;
    int t;
    t = cyc;
    if (!reset) begin
      chk("rst_outputs", {wrt_en_ep, wrt_en_op, insert_err, rt_ep_address, rt_op_address}, '0);
      chk("rst_data", rt_value_ep | rt_value_op, '0);
    end else begin
      ve = pend_e.exists(t);
      vo = pend_o.exists(t);
      e = '{default: 0};
      o = '{default: 0};
      if (ve) e = pend_e[t];
      if (vo) o = pend_o[t];
      col = ve && vo && (e.addr == o.addr);
      ey  = (e.issue > o.issue) || (e.issue == o.issue && !o.oy);
      chk("wrt_en_ep", wrt_en_ep, ve && !(col && !ey));
      chk("wrt_en_op", wrt_en_op, vo && !(col && ey));
      if (ve) begin
        chk("rt_ep_address", rt_ep_address, e.addr);
        chk("rt_value_ep", rt_value_ep, e.data);
      end
      if (vo) begin
        chk("rt_op_address", rt_op_address, o.addr);
        chk("rt_value_op", rt_value_op, o.data);
      end
      ee = exp_err.exists(t) ? exp_err[t] : 2'b00;
      chk("insert_err", insert_err, ee);
      if (ve) pend_e.delete(t);
      if (vo) pend_o.delete(t);
      if (exp_err.exists(t)) exp_err.delete(t);
    end
  end

  initial begin
    #1;
    assert_reset(3);
    // Single even write, latency 3.
    issue(1, 5, {16{8'hA5}}, 3, 0, 0, 0, 1, 0);
    idle(5);
    // Same-cycle collision, odd younger.
    issue(1, 9, 128'h1111, 2, 1, 9, 128'h2222, 2, 1);
    idle(3);
    // Same-cycle collision, even younger.
    issue(1, 9, 128'h3333, 2, 1, 9, 128'h4444, 2, 0);
    idle(3);
    // Cross-cycle collision: odd issued first, even younger.
    issue(0, 0, 0, 1, 1, 12, 128'hCAFE, 6, 0);
    idle(3);
    issue(1, 12, 128'hBEEF, 2, 0, 0, 0, 1, 0);
    idle(4);
    // Slot conflict on even pipe.
    issue(1, 20, 128'h44, 4, 0, 0, 0, 1, 0);
    issue(1, 21, 128'h33, 3, 0, 0, 0, 1, 0);
    idle(5);
    // Illegal odd latencies.
    issue(0, 0, 0, 1, 1, 30, 128'h7, 0, 0);
    issue(0, 0, 0, 1, 1, 31, 128'h8, 8, 0);
    idle(9);
    // Reset in flight discards the queued result.
    issue(1, 40, 128'h55, 5, 0, 0, 0, 1, 0);
    idle(1);
    assert_reset(1);
    idle(9);
    // Latency DEPTH on both pipes.
    issue(1, 50, 128'h66, 7, 1, 51, 128'h77, 7, 0);
    idle(8);
    // Randomized traffic with a small address space to provoke collisions.
    for (int i = 0; i < 600; i++) begin
      if (i % 150 == 149) assert_reset($urandom_range(1, 3));
      issue(($urandom_range(0, 9) < 7), AW'($urandom_range(0, 3)), {$urandom, $urandom, $urandom, $urandom},
            $urandom_range(0, 7),
            ($urandom_range(0, 9) < 7), AW'($urandom_range(0, 3)), {$urandom, $urandom, $urandom, $urandom},
            $urandom_range(0, 7), 1'($urandom_range(0, 1)));
    end
    idle(10);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
